// File: rtl/modmul_interleaved.sv
// Bit-serial interleaved modular multiplier Q = X*Y mod M with a loadable modulus table.
// Optional operand range check enabled by defining MODMUL_RANGE_CHECK_EN.
module modmul_interleaved #(
    parameter int W = 256,
    parameter int NMOD = 4,
    localparam int SW = $clog2(NMOD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  X,
    input  logic [W-1:0]  Y,
    input  logic [SW-1:0] mod_sel,
    input  logic          mod_we,
    input  logic [SW-1:0] mod_waddr,
    input  logic [W-1:0]  mod_wdata,
    output logic [W-1:0]  Q,
    output logic          done,
    output logic          busy,
    output logic          err
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_ITER  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [W-1:0]  tbl [NMOD];
    logic [W-1:0]  xr;
    logic [W-1:0]  yr;
    logic [W-1:0]  mr;
    logic [W-1:0]  rd_mod;
    logic [W+1:0]  acc;
    logic [W+1:0]  t;
    logic [W+1:0]  m1;
    logic [W+1:0]  m2;
    logic [W+1:0]  acc_nx;
    logic [CW-1:0] cnt;
    logic [1:0]    state;
    logic          wr_ok;
    logic          bad;

    assign wr_ok = mod_we && (int'(mod_waddr) < NMOD);

    always_comb begin
        rd_mod = tbl[0];
        if (int'(mod_sel) < NMOD)
            rd_mod = tbl[mod_sel];
    end

    // acc < mr keeps 2*acc + yr below 3*2^W, so W+2 bits never overflow
    always_comb begin
        m1 = {2'b00, mr};
        m2 = {1'b0, mr, 1'b0};
        t  = (acc << 1) + (xr[W-1] ? {2'b00, yr} : '0);
        if (t >= m2)
            acc_nx = t - m2;
        else if (t >= m1)
            acc_nx = t - m1;
        else
            acc_nx = t;
    end

`ifdef MODMUL_RANGE_CHECK_EN
    logic bad_r;

    assign bad = (mr == '0) || (xr >= mr) || (yr >= mr);

    always_ff @(posedge clk) begin
        if (rst) begin
            bad_r <= 1'b0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            unique case (state)
                S_IDLE:  bad_r <= 1'b0;
                S_CHECK: bad_r <= bad;
                S_DONE:  err   <= bad_r;
                default: ;
            endcase
        end
    end
`else
    assign bad = 1'b0;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            xr    <= '0;
            yr    <= '0;
            mr    <= '0;
            acc   <= '0;
            cnt   <= '0;
            Q     <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
            for (int i = 0; i < NMOD; i++)
                tbl[i] <= '0;
        end else begin
            done <= 1'b0;
            // Writes land after the read, so a same-cycle start sees the old entry
            if (wr_ok)
                tbl[mod_waddr] <= mod_wdata;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        xr    <= X;
                        yr    <= Y;
                        mr    <= rd_mod;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    state <= bad ? S_DONE : S_ITER;
                end
                S_ITER: begin
                    xr  <= {xr[W-2:0], 1'b0};
                    acc <= acc_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= S_DONE;
                end
                S_DONE: begin
                    Q     <= acc[W-1:0];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/modmul_interleaved.md
# modmul_interleaved

Parametrised sequential modular multiplier computing Q = X·Y mod M with the bit-serial interleaved (shift–add–reduce) algorithm. It is the next generation of the fold-based top-level multiplier. Operand width is generic, and the fixed hard-coded modulus set is replaced by a run-time-loadable modulus table. No external multiplier IP or BRAM is used, so it serves as a small-area alternative and as a reference engine for checking the Karatsuba/folding datapath.

## Interface
- W, default 256: operand, modulus and result width in bits; must be ≥ 4.
- NMOD, default 4: number of modulus table entries; must be ≥ 2. SW = $clog2(NMOD).
- clk, input, 1: the only clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request; accepted only in IDLE.
- X, input, W: multiplicand; sampled at the accepting edge.
- Y, input, W: multiplier; sampled at the accepting edge.
- mod_sel, input, SW: modulus table index; sampled at the accepting edge.
- mod_we, input, 1: table write enable; honoured in any state.
- mod_waddr, input, SW: table write index.
- mod_wdata, input, W: table write data.
- Q, output, W: result; registered; held until the next DONE.
- done, output, 1: one-cycle pulse when Q is updated.
- busy, output, 1: high from the accepting edge until the done edge.
- err, output, 1: range-check flag; valid with done (see Configuration).

## Operation
- Table: NMOD × W registers. A write occurs at the edge where mod_we is high. mod_waddr ≥ NMOD is ignored. A read with mod_sel ≥ NMOD returns entry 0.
- Accept: in IDLE with start high, the block latches X→xr, Y→yr, table[mod_sel]→mr, clears acc (W+2 bits) and the bit counter, and goes to CHECK.
- CHECK: one cycle, then ITER. Without the macro this state does nothing.
- ITER: runs exactly W cycles. Bit i goes from W-1 down to 0, taken MSB-first by left-shifting xr. Each cycle:
  - t = 2·acc + (xr[W-1] ? yr : 0), computed in W+2 bits.
  - If t ≥ 2·mr, subtract 2·mr; else if t ≥ mr, subtract mr.
  - acc ← the reduced t.
- Invariant: acc < mr after every iteration, provided yr < mr and mr > 0. The W+2-bit width guarantees no overflow.
- After the last iteration the block goes to DONE.
- DONE: Q ← acc[W-1:0], done pulses, busy falls, and the block returns to IDLE.
- A start in any non-IDLE state is ignored and not queued.
- States (2-bit encoding): IDLE=0, CHECK=1, ITER=2, DONE=3. Illegal encodings go to IDLE.

## Timing
- Reset values: Q=0, done=0, busy=0, err=0, state=IDLE, all table entries 0, acc=0.
- Reset mid-operation aborts the operation. No done is produced, and the table is cleared.
- Latency: if start is accepted at edge n, then CHECK occupies n+1, ITER occupies n+2 … n+W+1, and done/Q update at edge n+W+2. Total W+2 cycles.
- busy is high for edges n … n+W+1 and low at n+W+2.
- A new start may be accepted in the cycle after done: back-to-back throughput is one result per W+3 cycles.
- If mod_we and an accepting start hit the same entry in the same cycle, the operation uses the old value and the table takes the new value.
- A table write while busy does not affect the operation in flight.
- Q holds its value through IDLE and through the following operation until the next DONE.
- done and err are never high outside the DONE edge.

## Configuration
- MODMUL_RANGE_CHECK_EN defined:
  - In CHECK, if mr == 0, xr ≥ mr, or yr ≥ mr, the block skips ITER and goes to DONE.
  - It then produces Q=0, err=1 and done at edge n+2, with busy low at n+2.
  - Otherwise err=0 at done.
- MODMUL_RANGE_CHECK_EN undefined:
  - err is tied to 0 and CHECK always proceeds to ITER.
  - Results for out-of-range inputs are unspecified but deterministic, and latency is still W+2.

## Test plan
- Basic: W=8, write table[1]=251, then X=200, Y=123, mod_sel=1 → Q=2, done exactly 10 cycles after the accepting edge, busy high for 10 edges.
- Edge values: M=251 with X=250, Y=250 → Q=1; X=0, Y=77 → Q=0; X=1, Y=250 → Q=250. Run back-to-back, each accepted the cycle after the previous done.
- Table/concurrency: start with mod_sel=2 while writing table[2] in the same cycle; old value 13 → X=12, Y=11 gives Q=2. The next operation sees the new value. A start issued while busy is ignored, giving exactly one done.
- Reset mid-op: rst asserted 4 cycles after accept → done never pulses, Q=0, busy=0, table cleared. A fresh operation afterwards is correct.
- Range check (macro defined): M=251, X=251 → err=1, Q=0, done 2 cycles after accept. M=0 → err=1. Without the macro, err stays 0.
- Random: W=256, NMOD=4, 1000 random valid triples compared against a big-integer model; every result matches and every done arrives exactly 258 cycles after its accepting edge.
